// File: rtl/pe_mac_ws.sv
// Weight-stationary MAC processing element with shadow/active weights, valid qualification and optional 2-stage multiply.
// Define PE_SATURATE_EN to clamp the partial sum and drive sat_flag; otherwise the sum wraps modulo 2^AW.
module pe_mac_ws #(
    parameter int DW     = 8,
    parameter int AW     = 20,
    parameter int SIGNED = 1,
    parameter int PIPE   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] psum_in,
    input  logic [DW-1:0] w_in,
    input  logic          w_shift,
    input  logic          w_swap,
    output logic [DW-1:0] data_out,
    output logic          data_vld_out,
    output logic [AW-1:0] psum_out,
    output logic          psum_vld_out,
    output logic [DW-1:0] w_out,
    output logic          sat_flag,
    input  logic          sat_clr
);

    localparam bit            IS_SIGNED = (SIGNED != 0) ? 1'b1 : 1'b0;
    localparam logic [AW-1:0] SAT_MAX   = IS_SIGNED ? {1'b0, {(AW-1){1'b1}}} : {AW{1'b1}};
    localparam logic [AW-1:0] SAT_MIN   = IS_SIGNED ? {1'b1, {(AW-1){1'b0}}} : {AW{1'b0}};

    if (AW < 2*DW) begin : g_aw_check
        $error("pe_mac_ws: AW must be >= 2*DW");
    end
    if ((PIPE != 1) && (PIPE != 2)) begin : g_pipe_check
        $error("pe_mac_ws: PIPE must be 1 or 2");
    end

    // Extend the 2*DW product to the accumulator width according to the operand mode.
    function automatic logic [AW-1:0] ext_prod(input logic [2*DW-1:0] p);
        logic [AW-1:0] r;
        r = '0;
        r[2*DW-1:0] = p;
        for (int i = 2*DW; i < AW; i++) begin
            r[i] = IS_SIGNED & p[2*DW-1];
        end
        return r;
    endfunction

    logic [DW-1:0]   shadow_q, active_q;
    logic [DW-1:0]   data_q;
    logic            data_vld_q;
    logic [AW-1:0]   psum_q, psum_d;
    logic            psum_vld_q;
    logic            sat_q, sat_d;

    logic [2*DW-1:0] a_ext_s, w_ext_s, prod_s;
    logic [2*DW-1:0] mac_prod_s;
    logic [AW-1:0]   mac_psum_s;
    logic            mac_vld_s;
    logic [AW-1:0]   res_ext_s, res_s;
    logic            ovf_s, sat_hit_s;
`ifdef PE_SATURATE_EN
    logic [AW:0]     sum_s;
`endif

    // Shadow/active weight registers; a simultaneous swap takes the pre-shift shadow value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= {DW{1'b0}};
            active_q <= {DW{1'b0}};
        end else begin
            if (w_shift) shadow_q <= w_in;
            if (w_swap)  active_q <= shadow_q;
        end
    end

    // Activation forwarding to the east neighbour, data held across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= {DW{1'b0}};
            data_vld_q <= 1'b0;
        end else begin
            data_vld_q <= in_valid;
            if (in_valid) data_q <= data_in;
        end
    end

    // Product from width-extended operands; the low 2*DW bits are correct for both modes.
    always_comb begin
        a_ext_s = {{DW{IS_SIGNED & data_in[DW-1]}}, data_in};
        w_ext_s = {{DW{IS_SIGNED & active_q[DW-1]}}, active_q};
        prod_s  = a_ext_s * w_ext_s;
    end

    if (PIPE == 2) begin : g_pipe2
        logic [2*DW-1:0] prod_q;
        logic [AW-1:0]   psum_in_q;
        logic            vld_q;

        // Stage 1: capture product, incoming partial sum and valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod_q    <= {(2*DW){1'b0}};
                psum_in_q <= {AW{1'b0}};
                vld_q     <= 1'b0;
            end else begin
                vld_q <= in_valid;
                if (in_valid) begin
                    prod_q    <= prod_s;
                    psum_in_q <= psum_in;
                end
            end
        end

        assign mac_prod_s = prod_q;
        assign mac_psum_s = psum_in_q;
        assign mac_vld_s  = vld_q;
    end else begin : g_pipe1
        assign mac_prod_s = prod_s;
        assign mac_psum_s = psum_in;
        assign mac_vld_s  = in_valid;
    end

    // Accumulate, then clamp or wrap into AW bits.
    always_comb begin
        res_ext_s = ext_prod(mac_prod_s);
`ifdef PE_SATURATE_EN
        sum_s = {IS_SIGNED & res_ext_s[AW-1], res_ext_s} + {IS_SIGNED & mac_psum_s[AW-1], mac_psum_s};
        ovf_s = IS_SIGNED ? (sum_s[AW] != sum_s[AW-1]) : sum_s[AW];
        if (ovf_s) begin
            res_s = (IS_SIGNED && sum_s[AW]) ? SAT_MIN : SAT_MAX;
        end else begin
            res_s = sum_s[AW-1:0];
        end
`else
        res_s = res_ext_s + mac_psum_s;
        ovf_s = 1'b0;
`endif
        sat_hit_s = mac_vld_s & ovf_s;
    end

    // Output next-state: psum holds across bubbles, a new saturation beats a clear.
    always_comb begin
        psum_d = psum_q;
        sat_d  = sat_q;
        if (mac_vld_s) begin
            psum_d = res_s;
        end else begin
            psum_d = psum_q;
        end
        if (sat_hit_s) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    // Registered partial-sum outputs and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_q     <= {AW{1'b0}};
            psum_vld_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            psum_q     <= psum_d;
            psum_vld_q <= mac_vld_s;
            sat_q      <= sat_d;
        end
    end

    assign data_out     = data_q;
    assign data_vld_out = data_vld_q;
    assign psum_out     = psum_q;
    assign psum_vld_out = psum_vld_q;
    assign w_out        = shadow_q;
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_pe_mac_ws.sv
// Directed bench for pe_mac_ws: three instances (signed PIPE=1, signed PIPE=2, unsigned PIPE=1) share one stimulus stream.
module tb_pe_mac_ws;

`ifdef PE_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, w_shift, w_swap, sat_clr;
    logic [7:0]  data_in, w_in;
    logic [19:0] psum_in;

    logic [7:0]  data_a, data_b, data_c, wout_a, wout_b, wout_c;
    logic        dvld_a, dvld_b, dvld_c, pvld_a, pvld_b, pvld_c, sat_a, sat_b, sat_c;
    logic [19:0] psum_a, psum_b, psum_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_mac_ws #(.DW(8), .AW(20), .SIGNED(1), .PIPE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .psum_in(psum_in),
        .w_in(w_in), .w_shift(w_shift), .w_swap(w_swap), .data_out(data_a), .data_vld_out(dvld_a),
        .psum_out(psum_a), .psum_vld_out(pvld_a), .w_out(wout_a), .sat_flag(sat_a), .sat_clr(sat_clr));

    pe_mac_ws #(.DW(8), .AW(20), .SIGNED(1), .PIPE(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .psum_in(psum_in),
        .w_in(w_in), .w_shift(w_shift), .w_swap(w_swap), .data_out(data_b), .data_vld_out(dvld_b),
        .psum_out(psum_b), .psum_vld_out(pvld_b), .w_out(wout_b), .sat_flag(sat_b), .sat_clr(sat_clr));

    pe_mac_ws #(.DW(8), .AW(20), .SIGNED(0), .PIPE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .psum_in(psum_in),
        .w_in(w_in), .w_shift(w_shift), .w_swap(w_swap), .data_out(data_c), .data_vld_out(dvld_c),
        .psum_out(psum_c), .psum_vld_out(pvld_c), .w_out(wout_c), .sat_flag(sat_c), .sat_clr(sat_clr));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weight(input logic [7:0] w);
        w_in = w; w_shift = 1'b1; step();
        w_shift = 1'b0; w_swap = 1'b1; step();
        w_swap = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = 8'd0; psum_in = 20'd0;
        w_in = 8'd0; w_shift = 1'b0; w_swap = 1'b0; sat_clr = 1'b0;
        step(); step();
        check_eq("rst_psum", psum_a, 32'd0);
        check_eq("rst_pvld", pvld_a, 32'd0);
        check_eq("rst_data", data_a, 32'd0);
        check_eq("rst_wout", wout_a, 32'd0);
        check_eq("rst_sat",  sat_a,  32'd0);
        rst = 1'b0;

        // Basic MAC: 5*3+10
        w_in = 8'd3; w_shift = 1'b1; step();
        check_eq("shift_wout", wout_a, 32'd3);
        w_shift = 1'b0; w_swap = 1'b1; step();
        w_swap = 1'b0; in_valid = 1'b1; data_in = 8'd5; psum_in = 20'd10; step();
        check_eq("basic_psum_a", psum_a, 32'd25);
        check_eq("basic_pvld_a", pvld_a, 32'd1);
        check_eq("basic_data_a", data_a, 32'd5);
        check_eq("basic_dvld_a", dvld_a, 32'd1);
        check_eq("basic_pvld_b_early", pvld_b, 32'd0);
        check_eq("basic_data_b", data_b, 32'd5);
        check_eq("basic_dvld_b", dvld_b, 32'd1);
        check_eq("basic_psum_c", psum_c, 32'd25);
        in_valid = 1'b0; data_in = 8'd0; psum_in = 20'd0; step();
        check_eq("basic_pvld_a_after", pvld_a, 32'd0);
        check_eq("basic_psum_a_hold", psum_a, 32'd25);
        check_eq("basic_psum_b", psum_b, 32'd25);
        check_eq("basic_pvld_b", pvld_b, 32'd1);
        check_eq("basic_dvld_a_after", dvld_a, 32'd0);

        // Signed vs unsigned: 0xFE * 100
        load_weight(8'hFE);
        in_valid = 1'b1; data_in = 8'd100; psum_in = 20'd0; step();
        check_eq("signed_psum_a", psum_a, 32'h000FFF38);
        check_eq("unsigned_psum_c", psum_c, 32'd25400);
        in_valid = 1'b0; step();
        check_eq("signed_psum_b", psum_b, 32'h000FFF38);

        // Swap overlap: active=3, shadow=7, swap+shift(9) on cycle k
        load_weight(8'd3);
        w_in = 8'd7; w_shift = 1'b1; step();
        in_valid = 1'b1; data_in = 8'd1; psum_in = 20'd0;
        w_swap = 1'b1; w_shift = 1'b1; w_in = 8'd9; step();
        check_eq("swap_k_psum", psum_a, 32'd3);
        check_eq("swap_k_wout", wout_a, 32'd9);
        w_swap = 1'b0; w_shift = 1'b0; step();
        check_eq("swap_k1_psum", psum_a, 32'd7);
        in_valid = 1'b0; step();

        // Bubbles: valid 1,0,1 with data 2,x,4, w=5, psum_in=1
        load_weight(8'd5);
        in_valid = 1'b1; data_in = 8'd2; psum_in = 20'd1; step();
        check_eq("bub0_psum", psum_a, 32'd11);
        check_eq("bub0_pvld", pvld_a, 32'd1);
        in_valid = 1'b0; data_in = 8'hAA; psum_in = 20'h12345; step();
        check_eq("bub1_psum", psum_a, 32'd11);
        check_eq("bub1_pvld", pvld_a, 32'd0);
        check_eq("bub1_data_hold", data_a, 32'd2);
        check_eq("bub1_dvld", dvld_a, 32'd0);
        check_eq("bub1_psum_b", psum_b, 32'd11);
        check_eq("bub1_pvld_b", pvld_b, 32'd1);
        in_valid = 1'b1; data_in = 8'd4; psum_in = 20'd1; step();
        check_eq("bub2_psum", psum_a, 32'd21);
        check_eq("bub2_pvld", pvld_a, 32'd1);
        check_eq("bub2_pvld_b", pvld_b, 32'd0);
        check_eq("bub2_psum_b_hold", psum_b, 32'd11);
        in_valid = 1'b0; step();
        check_eq("bub3_psum_b", psum_b, 32'd21);
        check_eq("bub3_pvld_b", pvld_b, 32'd1);

        // Saturation / wrap: 524000 + 127*127
        load_weight(8'd127);
        in_valid = 1'b1; data_in = 8'd127; psum_in = 20'd524000; step();
        check_eq("ovf_psum_a", psum_a, SAT_EN ? 32'h0007FFFF : 32'h00083DE1);
        check_eq("ovf_sat_a", sat_a, {31'd0, SAT_EN});
        check_eq("ovf_psum_c", psum_c, 32'h00083DE1);
        check_eq("ovf_sat_c", sat_c, 32'd0);
        in_valid = 1'b0; sat_clr = 1'b1; step();
        check_eq("clr_sat_a", sat_a, 32'd0);
        // Underflow with a simultaneous clear: set must win
        in_valid = 1'b1; data_in = 8'h81; psum_in = 20'h80120; sat_clr = 1'b1; step();
        check_eq("unf_psum_a", psum_a, SAT_EN ? 32'h00080000 : 32'h0007C21F);
        check_eq("unf_sat_a", sat_a, {31'd0, SAT_EN});
        check_eq("unf_psum_c", psum_c, 32'h0008411F);
        in_valid = 1'b0; sat_clr = 1'b1; step();
        check_eq("clr2_sat_a", sat_a, 32'd0);
        sat_clr = 1'b0;

        // Asynchronous reset mid-stream flushes the pipeline
        in_valid = 1'b1; data_in = 8'd3; psum_in = 20'd2; step();
        check_eq("pre_rst_pvld", pvld_a, 32'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_psum_a", psum_a, 32'd0);
        check_eq("arst_pvld_a", pvld_a, 32'd0);
        check_eq("arst_data_a", data_a, 32'd0);
        check_eq("arst_dvld_a", dvld_a, 32'd0);
        check_eq("arst_wout_a", wout_a, 32'd0);
        check_eq("arst_pvld_b", pvld_b, 32'd0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        step();
        check_eq("post_rst_pvld_a", pvld_a, 32'd0);
        check_eq("post_rst_pvld_b", pvld_b, 32'd0);
        step();
        check_eq("post_rst2_pvld_b", pvld_b, 32'd0);
        check_eq("post_rst2_psum_a", psum_a, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
